// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle-event link: receiver FSM states,
// default sizing constants and the transmitter-side T flip-flop helper.
package toggle_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FULL = 2'd2
  } rx_state_e;

  // Transmitter side: each send request flips the remote Q line once.
  function automatic logic tff_next(input logic q, input logic toggle);
    return q ^ toggle;
  endfunction

endpackage

// File: rtl/toggle_sync_det.sv
// Synchronizes the remote toggle line and emits a registered one-cycle
// pulse for every level change seen at the synchronizer output.
module toggle_sync_det
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic                   pulse_q, pulse_d;

  // The reference register trails the synchronized level by one cycle.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tog_in};
    ref_d   = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] ^ ref_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      ref_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ref_q   <= ref_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign pulse = pulse_q;

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-event receiver: synchronizes a remote T flip-flop line, queues
// detected events in a saturating pending counter and keeps a total count.
module toggle_event_rx
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tog_in,
  input  logic              evt_ready,
  input  logic              count_clr,
  output logic              q_level,
  output logic              event_pulse,
  output logic              evt_valid,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  total_cnt,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              level_w, evt;
  logic              pop;
  rx_state_e         state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;

  toggle_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .tog_in (tog_in),
    .level  (level_w),
    .pulse  (evt)
  );

  assign pop = valid_q & evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Simultaneous event and pop cancel; an event that finds FULL with no pop is lost.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (evt) begin
          pend_d  = PEND_ONE;
          state_d = (PEND_ONE == PEND_MAX) ? ST_FULL : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (evt && !pop) begin
          pend_d = pend_q + PEND_ONE;
          if (pend_d == PEND_MAX) state_d = ST_FULL;
        end else if (!evt && pop) begin
          pend_d = pend_q - PEND_ONE;
          if (pend_d == '0) state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (evt && !pop) begin
          ovf_d = 1'b1;
        end else if (!evt && pop) begin
          pend_d  = PEND_MAX - PEND_ONE;
          state_d = (pend_d == '0) ? ST_IDLE : ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = '0;
      end
    endcase

    valid_d = (state_d != ST_IDLE);

    if (count_clr) begin
      total_d = CNT_W'(evt);
      ovf_d   = 1'b0;
    end else begin
      total_d = total_q + CNT_W'(evt);
    end
  end

  assign q_level     = level_w;
  assign event_pulse = evt;
  assign evt_valid   = valid_q;
  assign pending     = pend_q;
  assign total_cnt   = total_q;
  assign overflow    = ovf_q;

endmodule
